fifo_param: RTL and testbench

Parametrised synchronous FIFO for TLP buffering, the successor to the fixed 4-bit FIFO. Data width and depth are parameters. Almost-full and almost-empty thresholds are runtime inputs. Adds an occupancy count, a read-valid strobe and a sticky error flag. It sits between the TLP producer and the consumer inside each transaction-layer channel.

---
 rtl/fifo_param.sv | 113 +++++++++++
 tb/tb_fifo_param.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO for TLP buffering between producer and consumer.
// Registered read data with a read-valid strobe, occupancy count, runtime
// almost-full/almost-empty thresholds and a sticky overflow/underflow flag.
module fifo_param #(
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_a,
   input  logic                  push,
   input  logic                  pop,
   input  logic [ADDR_WIDTH:0]   af_thr,
   input  logic [ADDR_WIDTH:0]   ae_thr,
   output logic [DATA_WIDTH-1:0] q_b,
   output logic                  valid,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  error
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned CW    = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [CW-1:0]         count_q;
   logic [DATA_WIDTH-1:0] q_q;
   logic                  valid_q;
   logic                  error_q;

   logic                  push_ok;
   logic                  pop_ok;
   logic                  overflow;
   logic                  underflow;

   // Acceptance decisions against the pre-edge state; a full FIFO accepts a
   // push only when a pop frees a slot on the same edge.
   always_comb begin
      push_ok   = push & (~full | pop);
      pop_ok    = pop & ~empty;
      overflow  = push & full & ~pop;
      underflow = pop & empty;
   end

   // Storage array; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= data_a;
      end
   end

   // Pointers wrap naturally at DEPTH; occupancy tracked in a separate counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         end
         if (push_ok && !pop_ok) begin
            count_q <= count_q + CW'(1);
         end else if (pop_ok && !push_ok) begin
            count_q <= count_q - CW'(1);
         end
      end
   end

   // Registered read port: q_b holds between pops, valid marks a fresh word.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= pop_ok;
         if (pop_ok) begin
            q_q <= mem[rd_ptr];
         end
      end
   end

   // Sticky error: set on dropped push or empty pop, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         error_q <= 1'b0;
      end else if (overflow || underflow) begin
         error_q <= 1'b1;
      end
   end

   // Status flags decode the current count; thresholds act in the same cycle.
   always_comb begin
      full         = (count_q == CW'(DEPTH));
      empty        = (count_q == '0);
      almost_full  = (count_q >= af_thr);
      almost_empty = (count_q <= ae_thr);
   end

   assign q_b   = q_q;
   assign valid = valid_q;
   assign count = count_q;
   assign error = error_q;

endmodule

// File: tb/tb_fifo_param.sv
// Directed-vector bench for fifo_param (DATA_WIDTH=4, ADDR_WIDTH=3).
module tb_fifo_param;

   localparam int unsigned DW = 4;
   localparam int unsigned AW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] data_a;
   logic          push;
   logic          pop;
   logic [AW:0]   af_thr;
   logic [AW:0]   ae_thr;
   logic [DW-1:0] q_b;
   logic          valid;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic          error;

   int n_checks = 0;
   int n_fail   = 0;

   fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .data_a       (data_a),
      .push         (push),
      .pop          (pop),
      .af_thr       (af_thr),
      .ae_thr       (ae_thr),
      .q_b          (q_b),
      .valid        (valid),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .error        (error)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance one edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      push  = 1'b0;
      pop   = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      data_a = '0;
      af_thr = 4'd6;
      ae_thr = 4'd2;
      do_reset();

      // Reset state
      check("rst_q_b",   32'(q_b), 32'h0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_ae",    32'(almost_empty), 32'd1);
      check("rst_full",  32'(full), 32'd0);
      check("rst_af",    32'(almost_full), 32'd0);
      check("rst_error", 32'(error), 32'd0);

      // Fill with 1..8
      for (int i = 1; i <= 8; i++) begin
         push   = 1'b1;
         data_a = DW'(i);
         step();
         check("fill_count", 32'(count), 32'(i));
         check("fill_ae",    32'(almost_empty), (i <= 2) ? 32'd1 : 32'd0);
         check("fill_af",    32'(almost_full),  (i >= 6) ? 32'd1 : 32'd0);
         check("fill_full",  32'(full),         (i == 8) ? 32'd1 : 32'd0);
         check("fill_error", 32'(error), 32'd0);
      end

      // Overflow: push 9 into full FIFO
      data_a = 4'h9;
      step();
      check("ovf_error", 32'(error), 32'd1);
      check("ovf_count", 32'(count), 32'd8);
      check("ovf_full",  32'(full), 32'd1);

      // Drain: expect 1..8, no 9
      push = 1'b0;
      pop  = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         check("drain_q",     32'(q_b), 32'(i));
         check("drain_valid", 32'(valid), 32'd1);
         check("drain_count", 32'(count), 32'(8 - i));
         check("drain_error", 32'(error), 32'd1);
      end
      pop = 1'b0;
      step();
      check("drain_idle_valid", 32'(valid), 32'd0);
      check("drain_idle_q",     32'(q_b), 32'h8);
      check("drain_empty",      32'(empty), 32'd1);
      check("sticky_error",     32'(error), 32'd1);

      // Reset clears error
      do_reset();
      check("rst2_error", 32'(error), 32'd0);
      check("rst2_q_b",   32'(q_b), 32'h0);

      // Underflow with simultaneous push
      push   = 1'b1;
      pop    = 1'b1;
      data_a = 4'hA;
      step();
      check("unf_error", 32'(error), 32'd1);
      check("unf_valid", 32'(valid), 32'd0);
      check("unf_count", 32'(count), 32'd1);
      check("unf_q_b",   32'(q_b), 32'h0);
      push = 1'b0;
      step();
      check("unf_read_q",     32'(q_b), 32'hA);
      check("unf_read_valid", 32'(valid), 32'd1);
      check("unf_read_count", 32'(count), 32'd0);
      pop = 1'b0;

      // Full with push and pop together
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         push   = 1'b1;
         data_a = DW'(i);
         step();
      end
      check("full2_count", 32'(count), 32'd8);
      data_a = 4'hB;
      pop    = 1'b1;
      step();
      check("fpp_q_b",   32'(q_b), 32'h1);
      check("fpp_valid", 32'(valid), 32'd1);
      check("fpp_count", 32'(count), 32'd8);
      check("fpp_error", 32'(error), 32'd0);
      check("fpp_full",  32'(full), 32'd1);
      push = 1'b0;
      for (int i = 2; i <= 9; i++) begin
         step();
         check("fpp_drain_q", 32'(q_b), (i == 9) ? 32'hB : 32'(i));
      end
      check("fpp_drain_count", 32'(count), 32'd0);
      check("fpp_drain_error", 32'(error), 32'd0);
      pop = 1'b0;

      // Wrap-around streaming: prime 6 words (0..5), then push+pop 20 cycles
      for (int i = 0; i < 6; i++) begin
         push   = 1'b1;
         data_a = DW'(i);
         step();
      end
      check("prime_count", 32'(count), 32'd6);
      check("prime_af",    32'(almost_full), 32'd1);
      pop = 1'b1;
      for (int k = 0; k < 20; k++) begin
         data_a = DW'((k + 6) % 16);
         step();
         check("stream_q",     32'(q_b), 32'(k % 16));
         check("stream_valid", 32'(valid), 32'd1);
         check("stream_count", 32'(count), 32'd6);
         if (k == 10) begin
            af_thr = 4'd8;
            #1;
            check("stream_af_drop", 32'(almost_full), 32'd0);
            check("stream_af_cnt",  32'(count), 32'd6);
         end
      end
      check("stream_error", 32'(error), 32'd0);

      // Drain remaining 20..25 mod 16
      push = 1'b0;
      for (int k = 20; k < 26; k++) begin
         step();
         check("tail_q", 32'(q_b), 32'(k % 16));
      end
      pop = 1'b0;
      step();
      check("tail_empty", 32'(empty), 32'd1);
      check("tail_valid", 32'(valid), 32'd0);
      check("tail_error", 32'(error), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
